// File: rtl/ex_arith_pkg.sv
// Shared constants for the registered EX/IF/ID arithmetic unit: ALU opcode encodings and PC step.
package ex_arith_pkg;

  localparam int ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_AND  = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_NOR  = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 3'b101;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 3'b111;

  localparam int PC_INC = 4;

endpackage

// File: rtl/ex_alu_core.sv
// Purely combinational MIPS ALU: result, zero flag and (with EX_ARITH_OVF_EN) signed overflow.
module ex_alu_core
  import ex_arith_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]    a_i,
  input  logic [WIDTH-1:0]    b_i,
  input  logic [ALU_OP_W-1:0] op_i,
  output logic [WIDTH-1:0]    result_o,
`ifdef EX_ARITH_OVF_EN
  output logic                ovf_o,
`endif
  output logic                zero_o
);

  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;

  assign sum_s  = a_i + b_i;
  assign diff_s = a_i - b_i;

  // Operation select; compares produce a single LSB with upper bits cleared.
  always_comb begin
    result_o = {WIDTH{1'b0}};
    case (op_i)
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_ADD:  result_o = sum_s;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_NOR:  result_o = ~(a_i | b_i);
      ALU_SLTU: result_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      ALU_SUB:  result_o = diff_s;
      ALU_SLT:  result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default:  result_o = {WIDTH{1'b0}};
    endcase
  end

  assign zero_o = (result_o == {WIDTH{1'b0}});

`ifdef EX_ARITH_OVF_EN
  // Signed overflow only for ADD/SUB; judged from operand and result sign bits.
  always_comb begin
    ovf_o = 1'b0;
    case (op_i)
      ALU_ADD: ovf_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_s[WIDTH-1]  != a_i[WIDTH-1]);
      ALU_SUB: ovf_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff_s[WIDTH-1] != a_i[WIDTH-1]);
      default: ovf_o = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/ex_arith_unit.sv
// Registered ALU + PC+4 + branch-target adder, one-cycle latency.
// Optional signed-overflow output enabled by defining EX_ARITH_OVF_EN.
module ex_arith_unit
  import ex_arith_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    alu_a,
  input  logic [WIDTH-1:0]    alu_b,
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [WIDTH-1:0]    pc,
  input  logic [WIDTH-1:0]    pc_plus4_in,
  input  logic [WIDTH-1:0]    br_offset,
`ifdef EX_ARITH_OVF_EN
  output logic                overflow,
`endif
  output logic                out_valid,
  output logic [WIDTH-1:0]    alu_result,
  output logic                zero,
  output logic [WIDTH-1:0]    pc_plus4,
  output logic [WIDTH-1:0]    branch_target
);

  logic [WIDTH-1:0] alu_res_s;
  logic             alu_zero_s;
  logic [WIDTH-1:0] br_off_sh_s;

  logic             valid_d,  valid_q;
  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d,   zero_q;
  logic [WIDTH-1:0] pc4_d,    pc4_q;
  logic [WIDTH-1:0] bt_d,     bt_q;
`ifdef EX_ARITH_OVF_EN
  logic             alu_ovf_s;
  logic             ovf_d,    ovf_q;
`endif

  ex_alu_core #(.WIDTH(WIDTH)) u_alu (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .op_i     (alu_op),
    .result_o (alu_res_s),
`ifdef EX_ARITH_OVF_EN
    .ovf_o    (alu_ovf_s),
`endif
    .zero_o   (alu_zero_s)
  );

  // Offset is truncated to WIDTH bits before the add so both adders wrap.
  assign br_off_sh_s = br_offset << BR_SHIFT;

  // Load on in_valid, otherwise hold; valid simply follows in_valid.
  always_comb begin
    valid_d  = in_valid;
    result_d = result_q;
    zero_d   = zero_q;
    pc4_d    = pc4_q;
    bt_d     = bt_q;
`ifdef EX_ARITH_OVF_EN
    ovf_d    = ovf_q;
`endif
    if (in_valid) begin
      result_d = alu_res_s;
      zero_d   = alu_zero_s;
      pc4_d    = pc + WIDTH'(PC_INC);
      bt_d     = pc_plus4_in + br_off_sh_s;
`ifdef EX_ARITH_OVF_EN
      ovf_d    = alu_ovf_s;
`endif
    end else begin
      result_d = result_q;
    end
  end

  // Result registers; reset presents a zero result with the zero flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= {WIDTH{1'b0}};
      zero_q   <= 1'b1;
      pc4_q    <= {WIDTH{1'b0}};
      bt_q     <= {WIDTH{1'b0}};
`ifdef EX_ARITH_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      pc4_q    <= pc4_d;
      bt_q     <= bt_d;
`ifdef EX_ARITH_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign out_valid     = valid_q;
  assign alu_result    = result_q;
  assign zero          = zero_q;
  assign pc_plus4      = pc4_q;
  assign branch_target = bt_q;
`ifdef EX_ARITH_OVF_EN
  assign overflow      = ovf_q;
`endif

endmodule

// File: tb/tb_ex_arith_unit.sv
// Scoreboard bench for ex_arith_unit: expected results queued at drive time, popped one cycle later.
module tb_ex_arith_unit;

  typedef struct {
    logic [31:0] alu;
    logic        zero;
    logic [31:0] pc4;
    logic [31:0] bt;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] alu_a = 32'h0;
  logic [31:0] alu_b = 32'h0;
  logic [2:0]  alu_op = 3'b000;
  logic [31:0] pc = 32'h0;
  logic [31:0] pc_plus4_in = 32'h0;
  logic [31:0] br_offset = 32'h0;
  logic        out_valid;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
`ifdef EX_ARITH_OVF_EN
  logic        overflow;
`endif

  exp_t sb[$];
  exp_t last_exp;
  int   n_pass = 0;
  int   n_total = 0;

  ex_arith_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_op        (alu_op),
    .pc            (pc),
    .pc_plus4_in   (pc_plus4_in),
    .br_offset     (br_offset),
`ifdef EX_ARITH_OVF_EN
    .overflow      (overflow),
`endif
    .out_valid     (out_valid),
    .alu_result    (alu_result),
    .zero          (zero),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] p, input logic [31:0] pin, input logic [31:0] off);
    exp_t e;
    logic [32:0] wide;
    e.ovf = 1'b0;
    case (op)
      3'd0: e.alu = a & b;
      3'd1: e.alu = a | b;
      3'd2: begin
        e.alu = a + b;
        wide  = {a[31], a} + {b[31], b};
        e.ovf = wide[32] ^ wide[31];
      end
      3'd3: e.alu = a ^ b;
      3'd4: e.alu = ~(a | b);
      3'd5: e.alu = (a < b) ? 32'd1 : 32'd0;
      3'd6: begin
        e.alu = a + ~b + 32'd1;
        wide  = {a[31], a} + {~b[31], ~b} + 33'd1;
        e.ovf = wide[32] ^ wide[31];
      end
      default: e.alu = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
    endcase
    e.zero = (e.alu == 32'd0);
    e.pc4  = p + 32'd4;
    e.bt   = pin + {off[29:0], 2'b00};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic check_outputs(input string tag, input exp_t e, input logic vld);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, vld});
    chk({tag, ".alu"}, alu_result, e.alu);
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, e.zero});
    chk({tag, ".pc4"}, pc_plus4, e.pc4);
    chk({tag, ".bt"}, branch_target, e.bt);
`ifdef EX_ARITH_OVF_EN
    chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, e.ovf});
`endif
  endtask

  task automatic pop_check(input string tag);
    n_total++;
    assert (sb.size() > 0) n_pass++;
    else $error("FAIL %s.sb: observed %0d expected nonzero queue depth", tag, sb.size());
    if (sb.size() > 0) begin
      last_exp = sb.pop_front();
      check_outputs(tag, last_exp, 1'b1);
    end
  endtask

  task automatic send(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] p, input logic [31:0] pin, input logic [31:0] off);
    @(negedge clk);
    in_valid = 1'b1; alu_op = op; alu_a = a; alu_b = b;
    pc = p; pc_plus4_in = pin; br_offset = off;
    sb.push_back(model(op, a, b, p, pin, off));
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  initial begin
    exp_t rst_e;
    rst_e.alu = 32'd0; rst_e.zero = 1'b1; rst_e.pc4 = 32'd0; rst_e.bt = 32'd0; rst_e.ovf = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", rst_e, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    send("add",      3'd2, 32'h7,         32'h9,         32'h0040_0000, 32'h0040_0010, 32'hFFFF_FFFE);
    send("sub_eq",   3'd6, 32'h5,         32'h5,         32'hFFFF_FFFC, 32'h0040_0010, 32'h0000_0003);
    send("sub_neg",  3'd6, 32'h0,         32'h1,         32'h1234_5678, 32'h8000_0000, 32'h8000_0001);
    send("slt",      3'd7, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0,         32'h0);
    send("sltu",     3'd5, 32'hFFFF_FFFF, 32'h1,         32'h4,         32'h4,         32'h4);
    send("nor",      3'd4, 32'h0F0F_0000, 32'h0000_00F0, 32'h8,         32'h8,         32'h8);
    send("and",      3'd0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hC,         32'hC,         32'hC);
    send("or",       3'd1, 32'hA5A5_0000, 32'h0000_5A5A, 32'h10,        32'h10,        32'h10);
    send("xor",      3'd3, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h14,        32'h14,        32'h14);
    send("add_ovf",  3'd2, 32'h7FFF_FFFF, 32'h1,         32'h18,        32'h18,        32'h18);
    send("sub_ovf",  3'd6, 32'h8000_0000, 32'h1,         32'h1C,        32'h1C,        32'h1C);

    send("thr0", 3'd2, 32'h100, 32'h23, 32'h0040_0100, 32'h0040_0104, 32'h10);
    send("thr1", 3'd3, 32'hF0,  32'h0F, 32'h0040_0104, 32'h0040_0108, 32'hFFFF_FFF0);
    send("thr2", 3'd6, 32'h9,   32'h2,  32'h0040_0108, 32'h0040_010C, 32'h1);

    @(negedge clk);
    in_valid = 1'b0;
    alu_op = 3'd0; alu_a = 32'hDEAD_BEEF; alu_b = 32'h0; pc = 32'h0BAD_0000;
    pc_plus4_in = 32'h1; br_offset = 32'h1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("hold", last_exp, 1'b0);

    for (int i = 0; i < 16; i++) begin
      send($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), $urandom, $urandom,
           $urandom, $urandom, $urandom);
    end

    send("pre_rst", 3'd1, 32'h1234, 32'h0, 32'h40, 32'h44, 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_rst", rst_e, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    send("post_rst", 3'd2, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
